// File: rtl/shared_regfile_arb.sv
// shared_regfile_arb
//   Register file shared by NUM_PORTS cores with atomic READ / WRITE / TAS /
//   fetch-ADD operations. Ports that do not conflict are served in parallel.
//   Two ports conflict when they use the same address and at least one of
//   them modifies the register. The lower-ranked port is then held off for a
//   cycle. Port 0 is the RT-Core, and it has the highest rank in fixed mode.
//
//   Ports:
//     clk, rst_n    - clock, synchronous active-low reset
//     req           - per-port request, held until the matching ack
//     op            - per-port opcode, 2 bits each (00 RD, 01 WR, 10 TAS, 11 ADD)
//     addr          - per-port register index, ADDR_W bits each (MSB = out of range)
//     wdata         - per-port write data / addend, DATA_W bits each
//     ack           - per-port one-cycle completion pulse
//     rdata         - per-port old register value, zero outside the ack cycle
//     collision     - pulse the cycle after any port was blocked
//     conflict_cnt  - saturating count of blocked port-cycles
module shared_regfile_arb #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int ARB_MODE  = 0,
    localparam int ADDR_W   = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [2*NUM_PORTS-1:0]      op,
    input  logic [ADDR_W*NUM_PORTS-1:0] addr,
    input  logic [DATA_W*NUM_PORTS-1:0] wdata,
    output logic [NUM_PORTS-1:0]        ack,
    output logic [DATA_W*NUM_PORTS-1:0] rdata,
    output logic                        collision,
    output logic [15:0]                 conflict_cnt
);
    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_TAS   = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [PTR_W-1:0]             rr_ptr;
    logic [NUM_PORTS-1:0]         elig;
    logic [NUM_PORTS-1:0]         blocked;
    logic [NUM_PORTS-1:0]         served;
    logic [NUM_PORTS-1:0]         in_rng;
    logic [NUM_PORTS-1:0]         modify;
    logic [15:0]                  nblk;
    logic [ADDR_W-2:0]            idx     [NUM_PORTS];
    logic [DATA_W-1:0]            old_val [NUM_PORTS];
    logic [DATA_W-1:0]            new_val [NUM_PORTS];

    function automatic logic is_modify(input logic [1:0] o);
        return o != OP_READ;
    endfunction

    // True when port j ranks above port i. In rotating mode the rank is the
    // distance from rr_ptr going upward modulo NUM_PORTS.
    function automatic logic outranks(input int j, input int i, input logic [PTR_W-1:0] ptr);
        int pj;
        int pi;
        pj = (j + NUM_PORTS - int'(ptr)) % NUM_PORTS;
        pi = (i + NUM_PORTS - int'(ptr)) % NUM_PORTS;
        if (ARB_MODE == 0) return j < i;
        return pj < pi;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Stage 0: eligibility and conflict resolution
    always_comb begin
        elig    = req & ~ack;
        blocked = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                // Blocked ports still block lower ranks, so two served ports
                // sharing an address are always both reads.
                if (j != i && elig[i] && elig[j] && outranks(j, i, rr_ptr)
                    && addr[j*ADDR_W +: ADDR_W] == addr[i*ADDR_W +: ADDR_W]
                    && (is_modify(op[2*i +: 2]) || is_modify(op[2*j +: 2])))
                    blocked[i] = 1'b1;
            end
        end
        served = elig & ~blocked;
        nblk   = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (blocked[i]) nblk = nblk + 16'd1;
    end

    // Stage 0: per-port read-before-modify datapath
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            // DEPTH is a power of two, so the address MSB alone flags out of range.
            in_rng[i]  = ~addr[i*ADDR_W + ADDR_W - 1];
            idx[i]     = addr[i*ADDR_W +: ADDR_W-1];
            old_val[i] = in_rng[i] ? regs[idx[i]] : '0;
            modify[i]  = is_modify(op[2*i +: 2]);
            case (op[2*i +: 2])
                OP_WRITE: new_val[i] = wdata[i*DATA_W +: DATA_W];
                OP_TAS:   new_val[i] = DATA_W'(1);
                OP_ADD:   new_val[i] = old_val[i] + wdata[i*DATA_W +: DATA_W];
                default:  new_val[i] = old_val[i];
            endcase
        end
    end

    // Stage 1: commit, registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs         <= '0;
            ack          <= '0;
            rdata        <= '0;
            collision    <= 1'b0;
            conflict_cnt <= '0;
            rr_ptr       <= '0;
        end else begin
            ack          <= served;
            collision    <= |blocked;
            conflict_cnt <= sat_add16(conflict_cnt, nblk);
            if (|blocked)
                rr_ptr <= (rr_ptr == PTR_W'(NUM_PORTS - 1)) ? '0 : rr_ptr + PTR_W'(1);
            for (int i = 0; i < NUM_PORTS; i++) begin
                rdata[i*DATA_W +: DATA_W] <= served[i] ? old_val[i] : '0;
                if (served[i] && in_rng[i] && modify[i])
                    regs[idx[i]] <= new_val[i];
            end
        end
    end
endmodule

// File: tb/tb_shared_regfile_arb.sv
// Testbench for shared_regfile_arb: a fixed-priority instance (u0) and a
// rotating-priority instance (u1) share one set of inputs. The vector table
// is checked against u0 through a scoreboard queue. Hand-written sequences
// cover reset during a conflict and rotating arbitration.
module tb_shared_regfile_arb;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, TS = 2'b10, AD = 2'b11;

    typedef struct packed {
        logic [1:0]  req;
        logic [3:0]  op;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [1:0]  eack;
        logic [31:0] erd0;
        logic [31:0] erd1;
        logic        ecol;
        logic [15:0] ecnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [1:0]  ack0, ack1;
    logic [63:0] rdata0, rdata1;
    logic        col0, col1;
    logic [15:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;
    vec_t tbl [32];
    vec_t sb [$];

    always #5 clk = ~clk;

    shared_regfile_arb #(.NUM_PORTS(2), .DATA_W(32), .DEPTH(8), .ARB_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .ack(ack0), .rdata(rdata0), .collision(col0), .conflict_cnt(cnt0));

    shared_regfile_arb #(.NUM_PORTS(2), .DATA_W(32), .DEPTH(8), .ARB_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .ack(ack1), .rdata(rdata1), .collision(col1), .conflict_cnt(cnt1));

    function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] o0, input logic [1:0] o1,
                                input logic [3:0] a0, input logic [3:0] a1,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [1:0] eack, input logic [31:0] erd0,
                                input logic [31:0] erd1, input logic ecol, input logic [15:0] ecnt);
        vec_t v;
        v.req = rq; v.op = {o1, o0}; v.addr = {a1, a0}; v.wdata = {w1, w0};
        v.eack = eack; v.erd0 = erd0; v.erd1 = erd1; v.ecol = ecol; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic apply(input logic r, input logic [1:0] rq, input logic [3:0] o,
                         input logic [7:0] a, input logic [63:0] w);
        rst_n = r; req = rq; op = o; addr = a; wdata = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e;
        logic [1:0] exp_ack;

        //              req    op0 op1 a0 a1  w0            w1            ack    rd0           rd1           col cnt
        tbl[0]  = mk(2'b01, RD, RD, 3, 0, 32'h0,        32'h0,        2'b01, 32'h0,        32'h0,        0, 0);
        tbl[1]  = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 0);
        tbl[2]  = mk(2'b11, WR, WR, 2, 5, 32'hA5A5A5A5, 32'h1234,     2'b11, 32'h0,        32'h0,        0, 0);
        tbl[3]  = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 0);
        tbl[4]  = mk(2'b11, RD, RD, 2, 5, 32'h0,        32'h0,        2'b11, 32'hA5A5A5A5, 32'h1234,     0, 0);
        tbl[5]  = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 0);
        tbl[6]  = mk(2'b11, TS, TS, 1, 1, 32'h0,        32'h0,        2'b01, 32'h0,        32'h0,        1, 1);
        tbl[7]  = mk(2'b10, TS, TS, 1, 1, 32'h0,        32'h0,        2'b10, 32'h0,        32'h1,        0, 1);
        tbl[8]  = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 1);
        tbl[9]  = mk(2'b11, RD, RD, 1, 1, 32'h0,        32'h0,        2'b11, 32'h1,        32'h1,        0, 1);
        tbl[10] = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 1);
        tbl[11] = mk(2'b01, WR, RD, 3, 0, 32'hFFFFFFFF, 32'h0,        2'b01, 32'h0,        32'h0,        0, 1);
        tbl[12] = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 1);
        tbl[13] = mk(2'b01, AD, RD, 3, 0, 32'h1,        32'h0,        2'b01, 32'hFFFFFFFF, 32'h0,        0, 1);
        tbl[14] = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 1);
        tbl[15] = mk(2'b11, RD, WR, 3, 8, 32'h0,        32'hDEADBEEF, 2'b11, 32'h0,        32'h0,        0, 1);
        tbl[16] = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 1);
        tbl[17] = mk(2'b11, RD, RD, 0, 2, 32'h0,        32'h0,        2'b11, 32'h0,        32'hA5A5A5A5, 0, 1);
        tbl[18] = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 1);
        tbl[19] = mk(2'b11, WR, WR, 8, 8, 32'h5,        32'h6,        2'b01, 32'h0,        32'h0,        1, 2);
        tbl[20] = mk(2'b10, WR, WR, 8, 8, 32'h5,        32'h6,        2'b10, 32'h0,        32'h0,        0, 2);
        tbl[21] = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 2);
        tbl[22] = mk(2'b01, AD, RD, 4, 0, 32'h7,        32'h0,        2'b01, 32'h0,        32'h0,        0, 2);
        tbl[23] = mk(2'b01, AD, RD, 4, 0, 32'h7,        32'h0,        2'b00, 32'h0,        32'h0,        0, 2);
        tbl[24] = mk(2'b01, AD, RD, 4, 0, 32'h7,        32'h0,        2'b01, 32'h7,        32'h0,        0, 2);
        tbl[25] = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 2);
        tbl[26] = mk(2'b11, WR, RD, 6, 6, 32'h55,       32'h0,        2'b01, 32'h0,        32'h0,        1, 3);
        tbl[27] = mk(2'b10, WR, RD, 6, 6, 32'h55,       32'h0,        2'b10, 32'h0,        32'h55,       0, 3);
        tbl[28] = mk(2'b00, RD, RD, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        0, 3);
        tbl[29] = mk(2'b11, RD, AD, 6, 6, 32'h0,        32'h1,        2'b01, 32'h55,       32'h0,        1, 4);
        tbl[30] = mk(2'b10, RD, AD, 6, 6, 32'h0,        32'h1,        2'b10, 32'h0,        32'h55,       0, 4);
        tbl[31] = mk(2'b01, RD, RD, 6, 0, 32'h0,        32'h0,        2'b01, 32'h56,       32'h0,        0, 4);

        // Reset
        apply(1'b0, 2'b00, 4'h0, 8'h0, 64'h0);
        apply(1'b0, 2'b00, 4'h0, 8'h0, 64'h0);
        chk("rst ack0",   64'(ack0),   64'h0);
        chk("rst rdata0", rdata0,      64'h0);
        chk("rst col0",   64'(col0),   64'h0);
        chk("rst cnt0",   64'(cnt0),   64'h0);
        chk("rst ack1",   64'(ack1),   64'h0);
        chk("rst cnt1",   64'(cnt1),   64'h0);

        // Vector table through the scoreboard
        for (int k = 0; k < 32; k++) begin
            sb.push_back(tbl[k]);
            apply(1'b1, tbl[k].req, tbl[k].op, tbl[k].addr, tbl[k].wdata);
            e = sb.pop_front();
            chk($sformatf("v%0d ack", k),   64'(ack0),         64'(e.eack));
            chk($sformatf("v%0d rdata0", k), 64'(rdata0[31:0]),  64'(e.erd0));
            chk($sformatf("v%0d rdata1", k), 64'(rdata0[63:32]), 64'(e.erd1));
            chk($sformatf("v%0d col", k),   64'(col0),         64'(e.ecol));
            chk($sformatf("v%0d cnt", k),   64'(cnt0),         64'(e.ecnt));
        end

        // Reset arrives while port 1 is blocked
        apply(1'b1, 2'b00, 4'h0, 8'h0, 64'h0);
        apply(1'b1, 2'b11, {WR, WR}, {4'd7, 4'd7}, {32'h22, 32'h11});
        chk("rb ack", 64'(ack0), 64'h1);
        chk("rb col", 64'(col0), 64'h1);
        apply(1'b0, 2'b10, {WR, WR}, {4'd7, 4'd7}, {32'h22, 32'h11});
        chk("rb rst ack", 64'(ack0), 64'h0);
        chk("rb rst cnt", 64'(cnt0), 64'h0);
        chk("rb rst col", 64'(col0), 64'h0);
        apply(1'b1, 2'b00, 4'h0, 8'h0, 64'h0);
        chk("rb no ack1 a", 64'(ack0), 64'h0);
        apply(1'b1, 2'b00, 4'h0, 8'h0, 64'h0);
        chk("rb no ack1 b", 64'(ack0), 64'h0);
        apply(1'b1, 2'b11, {RD, RD}, {4'd7, 4'd2}, 64'h0);
        chk("rb read ack", 64'(ack0), 64'h3);
        chk("rb read a2",  64'(rdata0[31:0]), 64'h0);
        chk("rb read a7",  64'(rdata0[63:32]), 64'h0);
        chk("rb cnt",      64'(cnt0), 64'h0);

        // Rotating priority: both ports fetch-add 1 to addr 0 for 8 cycles
        apply(1'b0, 2'b00, 4'h0, 8'h0, 64'h0);
        apply(1'b0, 2'b00, 4'h0, 8'h0, 64'h0);
        for (int k = 0; k < 8; k++) begin
            apply(1'b1, 2'b11, {AD, AD}, 8'h00, {32'h1, 32'h1});
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr%0d ack", k), 64'(ack1), 64'(exp_ack));
            chk($sformatf("rr%0d rdata", k),
                64'(exp_ack[0] ? rdata1[31:0] : rdata1[63:32]), 64'(k));
        end
        chk("rr cnt", 64'(cnt1), 64'h1);
        apply(1'b1, 2'b01, {RD, RD}, 8'h00, 64'h0);
        chk("rr total ack", 64'(ack1), 64'h1);
        chk("rr total",     64'(rdata1[31:0]), 64'h8);
        apply(1'b1, 2'b00, 4'h0, 8'h0, 64'h0);
        // rr_ptr now points at port 1, so port 1 wins this conflict
        apply(1'b1, 2'b11, {TS, TS}, {4'd1, 4'd1}, 64'h0);
        chk("rr tas ack",   64'(ack1), 64'h2);
        chk("rr tas rd1",   64'(rdata1[63:32]), 64'h0);
        chk("rr tas col",   64'(col1), 64'h1);
        chk("rr tas cnt",   64'(cnt1), 64'h2);
        apply(1'b1, 2'b01, {TS, TS}, {4'd1, 4'd1}, 64'h0);
        chk("rr tas2 ack",  64'(ack1), 64'h1);
        chk("rr tas2 rd0",  64'(rdata1[31:0]), 64'h1);
        chk("rr tas2 col",  64'(col1), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shared_regfile_arb.md
SHARED_REGFILE_ARB -- requirements
Module: shared_regfile_arb

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requesting cores (2..4); port 0 is the RT-Core.
REQ-002 Parameter DATA_W, default 32, register width.
REQ-003 Parameter DEPTH, default 8, register count; power of two, at least 2.
REQ-004 Parameter ARB_MODE, default 0, conflict arbitration: 0 = fixed priority (lower index wins), 1 = rotating priority.
REQ-005 Derived ADDR_W = clog2(DEPTH) + 1; the MSB exists so that out-of-range addresses can be expressed.
REQ-006 Port clk, input, 1, single clock; all logic rises on posedge clk.
REQ-007 Port rst_n, input, 1; reset is synchronous and active-low, the only reset.
REQ-008 Port req, input, NUM_PORTS, per-port access request; held until the matching ack.
REQ-009 Port op, input, 2*NUM_PORTS, per-port opcode: 00 READ, 01 WRITE, 10 TAS (test-and-set), 11 ADD (fetch-add).
REQ-010 Port addr, input, ADDR_W*NUM_PORTS, per-port register index.
REQ-011 Port wdata, input, DATA_W*NUM_PORTS, per-port write or addend data.
REQ-012 Port ack, output, NUM_PORTS, registered one-cycle completion pulse per port.
REQ-013 Port rdata, output, DATA_W*NUM_PORTS, registered per-port data; valid only in the ack cycle.
REQ-014 Port collision, output, 1, registered pulse that is high the cycle after any port was blocked.
REQ-015 Port conflict_cnt, output, 16, saturating count of blocked port-cycles.

Function
REQ-016 Eligibility: port i is eligible in a cycle when req[i]=1 and ack[i]=0; req is ignored during its own ack cycle, so one port issues at most one access every 2 cycles.
REQ-017 Modifying ops are WRITE, TAS and ADD.
REQ-018 Blocking: an eligible port i is blocked when a higher-ranked eligible port j has addr_j == addr_i and op_i or op_j is modifying.
REQ-019 Non-blocked eligible ports are served in parallel in the same cycle.
REQ-020 Ranking when ARB_MODE=0: index order, with port 0 highest.
REQ-021 Ranking when ARB_MODE=1: order starts at rr_ptr and proceeds rr_ptr+1, ... modulo NUM_PORTS.
REQ-022 rr_ptr advances by 1 modulo NUM_PORTS at the end of every cycle in which at least one port was blocked; it holds otherwise.
REQ-023 In ARB_MODE=1, a continuously requesting port is served within NUM_PORTS cycles of first eligibility.
REQ-024 Latency: a port served in cycle T has ack=1 in cycle T+1, and the register update is visible to accesses served from T+1 onward.
REQ-025 rdata for every op equals the register value before the access (read-before-modify).
REQ-026 WRITE stores wdata.
REQ-027 TAS stores the value 1 zero-extended to DATA_W, unconditionally.
REQ-028 ADD stores (old + wdata) modulo 2^DATA_W; carry is discarded, so 0xFFFFFFFF + 1 = 0.
REQ-029 Out-of-range address (addr >= DEPTH): the port is still acked with rdata = 0, no register is modified, and it takes part in blocking as a normal address.
REQ-030 rdata for a port is 0 in any cycle that port's ack is 0.
REQ-031 collision is 1 in T+1 when at least one port was blocked in T.
REQ-032 conflict_cnt adds the number of ports blocked in T, saturating at 0xFFFF.
REQ-033 A blocked port keeps req and its inputs stable; changing op, addr or wdata before ack is undefined.

Reset
REQ-034 While rst_n=0 at a posedge, all registers are set to 0.
REQ-035 The same reset clears ack, rdata, collision, conflict_cnt and rr_ptr to 0.
REQ-036 A request pending or blocked when reset asserts is discarded; it produces no ack and no write, and must be re-presented after reset.
REQ-037 An access served in the same cycle reset is sampled low has no effect.

Verification
REQ-038 Reset, then port 0 READ addr 3 -> ack[0] pulses 1 cycle later with rdata = 0; collision stays 0.
REQ-039 Port 0 WRITE addr 2 = 0xA5A5A5A5 and port 1 WRITE addr 5 = 0x1234 in the same cycle -> both acked in the next cycle with collision = 0; subsequent READs return both values.
REQ-040 ARB_MODE=0: both ports TAS addr 1 (initially 0) simultaneously -> port 0 acked with rdata 0, collision = 1, and conflict_cnt = 1; port 1 acked 1 cycle later with rdata 1.
REQ-041 ARB_MODE=1, NUM_PORTS=2: both ports hold ADD addr 0 with wdata 1 continuously for 8 cycles -> acks alternate between ports, neither port waits more than 1 cycle, and the final value equals the total number of acks.
REQ-042 ADD of 1 to a register holding 0xFFFFFFFF -> rdata = 0xFFFFFFFF, register becomes 0; WRITE to addr 8 with DEPTH=8 -> ack with rdata 0 and no register changed.
REQ-043 rst_n driven low while port 1 is blocked -> no ack[1] follows, all registers read 0, and conflict_cnt = 0.
